// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues reads to a 1-cycle synchronous instruction memory and queues returned words with their PCs.
// Latency: issue at cycle N, push at the end of N+1, so the head is valid at N+2. Redirect flushes and refetches the cycle after.
// Backpressure: a read issues only while (fifo_count + inflight) < DEPTH. inst_ready only drains the head, so the FIFO never overflows.
module fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_en,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [XLEN-1:0]            inst_pc,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  // Read-tracking state: WAIT means a memory response arrives this cycle
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state;
  logic            inflight;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] tag_pc;
  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            mis_q;
  logic            push;
  logic            pop;

  assign inflight = (state == WAIT);

  // Outstanding read counts as an occupied slot; a same-cycle pop does not free one
  assign imem_en   = !reset && !redirect_valid && ((count + CW'(inflight)) < DEPTH_C);
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  // A redirect kills both the returning response and any consumer handshake
  assign push = inflight && !redirect_valid;
  assign pop  = (count != '0) && inst_ready && !redirect_valid;

  assign inst_valid   = (count != '0);
  assign inst         = inst_valid ? mem_inst[rd_ptr] : NOP;
  assign inst_pc      = inst_valid ? mem_pc[rd_ptr] : '0;
  assign fifo_count   = count;
  assign misalign_err = mis_q;

  // Fetch PC, response tag and in-flight state; redirect overrides issue
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      state    <= IDLE;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      state    <= IDLE;
    end else if (imem_en) begin
      tag_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + XLEN'(4);
      state    <= WAIT;
    end else begin
      state    <= IDLE;
    end
  end

  // FIFO payload storage; contents are only observed through valid slots
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_inst[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= tag_pc;
    end
  end

  // FIFO pointers and occupancy; reset and redirect both empty the queue
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // One-cycle pulse after a redirect to a non-word-aligned target
  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: reset and streaming vectors, hand sequences for
// redirect/misalign/reset/wrap, then random traffic against a queue model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign_err;
  logic [2:0]  fifo_count;

  int n_chk = 0;
  int n_fail = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .misalign_err(misalign_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word i holds value i, 1-cycle read latency
  always @(posedge clk) if (imem_en) imem_rdata <= {24'h0, imem_addr};

  // Reference model: a queue of delivered words plus the fetch pointer
  typedef struct { logic [31:0] i; logic [63:0] pc; } ent_t;
  ent_t        q[$];
  logic [63:0] m_pc = '0;
  logic [63:0] m_tag = '0;
  bit          m_infl = 0;
  bit          m_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, compare against model, advance model past the edge
  task automatic step(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy, input bit do_chk);
    bit issue;
    @(posedge clk);
    #1;
    reset = rst; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    #1;
    issue = !rst && !rv && ((q.size() + int'(m_infl)) < DEPTH);
    if (do_chk) begin
      check("m_en", imem_en, issue);
      check("m_addr", imem_addr, m_pc[9:2]);
      check("m_vld", inst_valid, q.size() != 0);
      check("m_inst", inst, q.size() != 0 ? q[0].i : 32'h13);
      check("m_pc", inst_pc, q.size() != 0 ? q[0].pc : 64'd0);
      check("m_cnt", fifo_count, q.size());
      check("m_mis", misalign_err, m_mis);
    end
    if (rst) begin
      q.delete(); m_pc = 64'd0; m_infl = 0; m_mis = 0;
    end else if (rv) begin
      q.delete(); m_pc = rpc & ~64'd3; m_infl = 0; m_mis = (rpc[1:0] != 2'b00);
    end else begin
      m_mis = 0;
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (m_infl) q.push_back('{i: {24'h0, m_tag[9:2]}, pc: m_tag});
      m_infl = issue;
      if (issue) begin m_tag = m_pc; m_pc = m_pc + 64'd4; end
    end
  endtask

  typedef struct {
    bit rst; bit rdy; bit en; logic [7:0] addr; bit vld;
    logic [31:0] inst; logic [63:0] pc; logic [2:0] cnt;
  } vec_t;
  vec_t tbl[19];

  initial begin
    // rst rdy en addr vld inst pc cnt
    tbl[0]  = '{1, 1, 0, 8'd0, 0, 32'h13, 64'd0,  3'd0};
    tbl[1]  = '{0, 1, 1, 8'd0, 0, 32'h13, 64'd0,  3'd0};
    tbl[2]  = '{0, 1, 1, 8'd1, 0, 32'h13, 64'd0,  3'd0};
    tbl[3]  = '{0, 1, 1, 8'd2, 1, 32'd0,  64'd0,  3'd1};
    tbl[4]  = '{0, 1, 1, 8'd3, 1, 32'd1,  64'd4,  3'd1};
    tbl[5]  = '{0, 1, 1, 8'd4, 1, 32'd2,  64'd8,  3'd1};
    tbl[6]  = '{1, 0, 0, 8'd5, 1, 32'd3,  64'd12, 3'd1};
    tbl[7]  = '{0, 0, 1, 8'd0, 0, 32'h13, 64'd0,  3'd0};
    tbl[8]  = '{0, 0, 1, 8'd1, 0, 32'h13, 64'd0,  3'd0};
    tbl[9]  = '{0, 0, 1, 8'd2, 1, 32'd0,  64'd0,  3'd1};
    tbl[10] = '{0, 0, 1, 8'd3, 1, 32'd0,  64'd0,  3'd2};
    tbl[11] = '{0, 0, 0, 8'd4, 1, 32'd0,  64'd0,  3'd3};
    tbl[12] = '{0, 0, 0, 8'd4, 1, 32'd0,  64'd0,  3'd4};
    tbl[13] = '{0, 0, 0, 8'd4, 1, 32'd0,  64'd0,  3'd4};
    tbl[14] = '{0, 1, 0, 8'd4, 1, 32'd0,  64'd0,  3'd4};
    tbl[15] = '{0, 1, 1, 8'd4, 1, 32'd1,  64'd4,  3'd3};
    tbl[16] = '{0, 1, 1, 8'd5, 1, 32'd2,  64'd8,  3'd2};
    tbl[17] = '{0, 1, 1, 8'd6, 1, 32'd3,  64'd12, 3'd2};
    tbl[18] = '{0, 1, 1, 8'd7, 1, 32'd4,  64'd16, 3'd2};

    step(1, 0, 64'd0, 0, 0);

    // Streaming from reset, then fill with ready low and drain in order
    for (int k = 0; k < 19; k++) begin
      step(tbl[k].rst, 0, 64'd0, tbl[k].rdy, 1);
      check($sformatf("tbl%0d en", k), imem_en, tbl[k].en);
      check($sformatf("tbl%0d addr", k), imem_addr, tbl[k].addr);
      check($sformatf("tbl%0d vld", k), inst_valid, tbl[k].vld);
      check($sformatf("tbl%0d inst", k), inst, tbl[k].inst);
      check($sformatf("tbl%0d pc", k), inst_pc, tbl[k].pc);
      check($sformatf("tbl%0d cnt", k), fifo_count, tbl[k].cnt);
      check($sformatf("tbl%0d mis", k), misalign_err, 1'b0);
    end

    // Redirect with 3 queued entries and a read in flight
    step(1, 0, 64'd0, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 64'd0, 0, 1);
    step(0, 1, 64'h100, 0, 1);
    check("rd3 pre cnt", fifo_count, 3'd3);
    step(0, 0, 64'd0, 1, 1);
    check("rd3 cnt", fifo_count, 3'd0);
    check("rd3 vld", inst_valid, 1'b0);
    check("rd3 en", imem_en, 1'b1);
    check("rd3 addr", imem_addr, 8'h40);
    step(0, 0, 64'd0, 1, 1);
    step(0, 0, 64'd0, 1, 1);
    check("rd3 first pc", inst_pc, 64'h100);

    // Misaligned redirect target
    step(0, 1, 64'h202, 1, 1);
    step(0, 0, 64'd0, 1, 1);
    check("mis pulse", misalign_err, 1'b1);
    step(0, 0, 64'd0, 1, 1);
    check("mis clear", misalign_err, 1'b0);
    step(0, 0, 64'd0, 1, 1);
    check("mis first pc", inst_pc, 64'h200);

    // Reset with the FIFO full
    step(1, 0, 64'd0, 0, 1);
    for (int k = 0; k < 6; k++) step(0, 0, 64'd0, 0, 1);
    check("rst5 full", fifo_count, 3'd4);
    step(1, 0, 64'd0, 0, 1);
    step(0, 0, 64'd0, 1, 1);
    check("rst5 vld", inst_valid, 1'b0);
    check("rst5 cnt", fifo_count, 3'd0);
    check("rst5 inst", inst, 32'h13);
    check("rst5 pc", inst_pc, 64'd0);
    check("rst5 addr", imem_addr, 8'd0);
    step(0, 0, 64'd0, 1, 1);
    step(0, 0, 64'd0, 1, 1);
    check("rst5 restart pc", inst_pc, 64'd0);
    check("rst5 restart vld", inst_valid, 1'b1);

    // PC wrap at the top of the address space
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
    step(0, 0, 64'd0, 1, 1);
    check("wrap addr0", imem_addr, 8'hFF);
    step(0, 0, 64'd0, 1, 1);
    check("wrap addr1", imem_addr, 8'h00);
    step(0, 0, 64'd0, 1, 1);
    check("wrap pc0", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 64'd0, 1, 1);
    check("wrap pc1", inst_pc, 64'd0);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      bit rst, rv, rdy;
      logic [63:0] rpc;
      rst = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) rpc[63:12] = '1;
      step(rst, rv, rpc, rdy, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
